hazard_tracker: RTL

Producer side of the EX-stage forwarding interface in the 5-stage MIPS pipeline. Carries destination-register bookkeeping (RegWrite, MemRead, Rd, Rs, Rt) through the ID/EX, EX/MEM and MEM/WB pipeline registers and drives those fields to the forwarding unit. Detects load-use hazards, inserts bubbles, generates PC/IF-ID hold and flush controls, and keeps a saturating stall counter. Sits alongside the datapath pipeline registers and is clocked with them.

---
 rtl/hazard_tracker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Destination-register bookkeeping, load-use detection and PC/IF-ID control for the 5-stage pipeline.
// Define HAZ_BRANCH_ID_EN to resolve branches in ID (extra branch-operand stalls, IF/ID-only flush).
module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_RegisterRs,
  input  logic [4:0]       IFID_RegisterRt,
  input  logic [4:0]       ID_RegisterRd,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_Branch,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             Stall,
  output logic [4:0]       IDEX_RegisterRs,
  output logic [4:0]       IDEX_RegisterRt,
  output logic [4:0]       IDEX_RegisterRd,
  output logic             IDEX_RegWrite,
  output logic             IDEX_MemRead,
  output logic             EXMEM_RegWrite,
  output logic [4:0]       EXMEM_RegisterRd,
  output logic             EXMEM_MemRead,
  output logic             MEMWB_RegWrite,
  output logic [4:0]       MEMWB_RegisterRd,
  output logic [CNT_W-1:0] StallCount
);

  logic loadUse;
  logic bubble;
  logic idexSrcHit;

  assign idexSrcHit = (IDEX_RegisterRd != 5'd0) &&
                      ((IDEX_RegisterRd == IFID_RegisterRs) || (IDEX_RegisterRd == IFID_RegisterRt));
  assign loadUse    = IDEX_MemRead && idexSrcHit;

`ifdef HAZ_BRANCH_ID_EN
  logic exmemSrcHit;
  logic branchHaz;

  assign exmemSrcHit = (EXMEM_RegisterRd != 5'd0) &&
                       ((EXMEM_RegisterRd == IFID_RegisterRs) || (EXMEM_RegisterRd == IFID_RegisterRt));
  assign branchHaz   = ID_Branch && ((IDEX_RegWrite && idexSrcHit) || (EXMEM_MemRead && exmemSrcHit));

  // A pending stall wins over BranchTaken; the flush only clears IF/ID.
  always_comb begin
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    IFIDFlush = 1'b0;
    Stall     = 1'b0;
    bubble    = 1'b0;
    if (!rst) begin
      if (loadUse || branchHaz) begin
        Stall  = 1'b1;
        bubble = 1'b1;
      end else begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = BranchTaken;
      end
    end
  end
`else
  logic unusedBranch;
  assign unusedBranch = ID_Branch;

  // EX-resolved branch squashes both IF/ID and ID/EX and overrides the load-use stall.
  always_comb begin
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    IFIDFlush = 1'b0;
    Stall     = 1'b0;
    bubble    = 1'b0;
    if (!rst) begin
      if (BranchTaken) begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b1;
        bubble    = 1'b1;
      end else if (loadUse) begin
        Stall  = 1'b1;
        bubble = 1'b1;
      end else begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      IDEX_RegisterRs  <= '0;
      IDEX_RegisterRt  <= '0;
      IDEX_RegisterRd  <= '0;
      IDEX_RegWrite    <= 1'b0;
      IDEX_MemRead     <= 1'b0;
      EXMEM_RegWrite   <= 1'b0;
      EXMEM_RegisterRd <= '0;
      EXMEM_MemRead    <= 1'b0;
      MEMWB_RegWrite   <= 1'b0;
      MEMWB_RegisterRd <= '0;
      StallCount       <= '0;
    end else begin
      MEMWB_RegWrite   <= EXMEM_RegWrite;
      MEMWB_RegisterRd <= EXMEM_RegisterRd;
      EXMEM_RegWrite   <= IDEX_RegWrite;
      EXMEM_RegisterRd <= IDEX_RegisterRd;
      EXMEM_MemRead    <= IDEX_MemRead;
      if (bubble) begin
        IDEX_RegisterRs <= '0;
        IDEX_RegisterRt <= '0;
        IDEX_RegisterRd <= '0;
        IDEX_RegWrite   <= 1'b0;
        IDEX_MemRead    <= 1'b0;
      end else begin
        IDEX_RegisterRs <= IFID_RegisterRs;
        IDEX_RegisterRt <= IFID_RegisterRt;
        IDEX_RegisterRd <= ID_RegisterRd;
        IDEX_RegWrite   <= ID_RegWrite;
        IDEX_MemRead    <= ID_MemRead;
      end
      if (Stall && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
    end
  end

endmodule
